// File: rtl/fft_bfly_sequencer_pkg.sv
// fft_pkg: shared constants, FSM state encoding and twiddle-angle helper for the FFT butterfly sequencer.
package fft_pkg;
    localparam int ANGLE_W = 32;
    localparam int LOG2N_DEF = 3;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;
    // full scale 2^ANGLE_W = 360 deg, so j << (ANGLE_W-1-s) is j * 180/2^s deg
    function automatic logic [ANGLE_W-1:0] twiddle(input logic [3:0] s, input logic [9:0] j, input logic inverse);
        logic [ANGLE_W-1:0] mag;
        mag = ANGLE_W'(j) << (6'(ANGLE_W - 1) - 6'(s));
        return inverse ? mag : -mag;
    endfunction
endpackage

// File: rtl/fft_bfly_sequencer_if.sv
// fft_bfly_sequencer_if: control, sample-address and butterfly handshake bundle.
// The `inverse` input exists only when FFT_INVERSE_EN is defined.
interface fft_bfly_sequencer_if import fft_pkg::*; #(parameter int LOG2N = LOG2N_DEF);
    logic start, busy, done, bf_start, bf_done, wr_en;
    logic [LOG2N-1:0] rd_addr_a, rd_addr_b;
    logic [ANGLE_W-1:0] zangle;
`ifdef FFT_INVERSE_EN
    logic inverse;
    modport master(input start, bf_done, inverse, output busy, done, rd_addr_a, rd_addr_b, zangle, bf_start, wr_en);
    modport slave(output start, bf_done, inverse, input busy, done, rd_addr_a, rd_addr_b, zangle, bf_start, wr_en);
`else
    modport master(input start, bf_done, output busy, done, rd_addr_a, rd_addr_b, zangle, bf_start, wr_en);
    modport slave(output start, bf_done, input busy, done, rd_addr_a, rd_addr_b, zangle, bf_start, wr_en);
`endif
endinterface

// File: rtl/fft_twiddle_addr.sv
// fft_twiddle_addr: combinational (stage, butterfly) -> (upper/lower sample address, twiddle angle).
module fft_twiddle_addr import fft_pkg::*; #(parameter int LOG2N = LOG2N_DEF) (
    input  logic [3:0]         s,
    input  logic [LOG2N-1:0]   b,
    input  logic               inverse,
    output logic [LOG2N-1:0]   addr_a,
    output logic [LOG2N-1:0]   addr_b,
    output logic [ANGLE_W-1:0] angle
);
    logic [LOG2N-1:0] h, j;
    always_comb begin
        h = LOG2N'(1) << s;
        j = b & (h - LOG2N'(1));
        addr_a = ((b >> s) << (s + 4'd1)) | j;
        addr_b = addr_a + h;
        angle = twiddle(s, 10'(j), inverse);
    end
endmodule

// File: rtl/fft_bfly_sequencer.sv
// fft_bfly_sequencer: walks every radix-2 DIT stage/butterfly, issuing addresses, twiddle and write-back.
// Define FFT_INVERSE_EN to add the `inverse` input (captured at start) selecting IFFT twiddles.
module fft_bfly_sequencer import fft_pkg::*; #(parameter int LOG2N = LOG2N_DEF) (
    input logic                   clock,
    input logic                   resetn,
    fft_bfly_sequencer_if.master  bus
);
    localparam logic [LOG2N-1:0] B_LAST = LOG2N'((1 << (LOG2N - 1)) - 1);
    localparam logic [3:0] S_LAST = 4'(LOG2N - 1);
    state_t state, state_n;
    logic [3:0] s, s_n;
    logic [LOG2N-1:0] b, b_n, addr_a, addr_b;
    logic [ANGLE_W-1:0] angle;
    logic inv_sel;
`ifdef FFT_INVERSE_EN
    logic inv_q;
    always_ff @(posedge clock)
        if (!resetn) inv_q <= 1'b0;
        else if (state == IDLE && bus.start) inv_q <= bus.inverse;
    // the first ISSUE is loaded on the start edge, before inv_q has caught the flag
    assign inv_sel = (state == IDLE) ? bus.inverse : inv_q;
`else
    assign inv_sel = 1'b0;
`endif
    fft_twiddle_addr #(.LOG2N(LOG2N)) u_map (
        .s(s_n), .b(b_n), .inverse(inv_sel), .addr_a(addr_a), .addr_b(addr_b), .angle(angle)
    );
    always_comb begin
        state_n = state;
        s_n = s;
        b_n = b;
        unique case (state)
            IDLE: if (bus.start) begin
                state_n = ISSUE;
                s_n = '0;
                b_n = '0;
            end
            ISSUE: state_n = WAIT;
            WAIT: state_n = bus.bf_done ? WRITE : WAIT;
            WRITE: begin
                state_n = (s == S_LAST && b == B_LAST) ? DONE : ISSUE;
                b_n = (b == B_LAST) ? '0 : b + LOG2N'(1);
                s_n = (b == B_LAST) ? s + 4'd1 : s;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
            s <= '0;
            b <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.bf_start <= 1'b0;
            bus.wr_en <= 1'b0;
            bus.rd_addr_a <= '0;
            bus.rd_addr_b <= '0;
            bus.zangle <= '0;
        end else begin
            state <= state_n;
            s <= s_n;
            b <= b_n;
            bus.busy <= state_n inside {ISSUE, WAIT, WRITE};
            bus.done <= state_n == DONE;
            bus.bf_start <= state_n == ISSUE;
            bus.wr_en <= state_n == WRITE;
            if (state_n == ISSUE) begin
                bus.rd_addr_a <= addr_a;
                bus.rd_addr_b <= addr_b;
                bus.zangle <= angle;
            end
        end
    end
endmodule
